// File: rtl/ahb_matrix_pkg.sv
// Shared AHB bus-matrix definitions: transfer/response encodings, decode width, default-slave states
// and the inclusive region-compare helper.
package ahb_matrix_pkg;

    localparam int DEC_ADDR_W = 22;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    // Inclusive bounds at 1 KB granularity (addr is HADDR[31:10]).
    function automatic logic addr_in_range(input logic [DEC_ADDR_W-1:0] addr,
                                           input logic [DEC_ADDR_W-1:0] lo,
                                           input logic [DEC_ADDR_W-1:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/ahb_matrix_default_slave_ah.sv
// Default slave for unmapped addresses: answers every NONSEQ/SEQ with the two-cycle AHB ERROR
// response and IDLE/BUSY with a zero-wait OKAY. Asynchronous active-high reset.
module ahb_matrix_default_slave_ah
    import ahb_matrix_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       xfer_req,
    output logic       ds_readyout,
    output logic [1:0] ds_resp
);

    ds_state_t state_reg;
    ds_state_t state_next;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg <= DS_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ds_readyout = 1'b1;
        ds_resp     = HRESP_OKAY;
        case (state_reg)
            DS_IDLE: begin
                if (xfer_req) state_next = DS_ERR1;
            end
            DS_ERR1: begin
                ds_readyout = 1'b0;
                ds_resp     = HRESP_ERROR;
                state_next  = DS_ERR2;
            end
            DS_ERR2: begin
                ds_resp    = HRESP_ERROR;
                state_next = xfer_req ? DS_ERR1 : DS_IDLE;
            end
            default: state_next = DS_IDLE;
        endcase
    end

endmodule

// File: rtl/ahb_matrix_decode_param.sv
// Bus-matrix input-stage decoder: region decode, one-hot output-port select, data-phase response mux.
// Optional macro AHB_DECODE_REMAP_EN adds the remap input that moves port0 to REMAP_BASE..REMAP_LIMIT.
module ahb_matrix_decode_param
    import ahb_matrix_pkg::*;
#(
    parameter int                           NUM_MI       = 2,
    parameter int                           RDATA_W      = 32,
    parameter int                           RUSER_W      = 32,
    parameter logic [NUM_MI*DEC_ADDR_W-1:0] REGION_BASE  = {22'h100000, 22'h080000},
    parameter logic [NUM_MI*DEC_ADDR_W-1:0] REGION_LIMIT = {22'h13ffff, 22'h08003f},
    parameter logic [DEC_ADDR_W-1:0]        REMAP_BASE   = 22'h000000,
    parameter logic [DEC_ADDR_W-1:0]        REMAP_LIMIT  = 22'h00003f
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      HREADYS,
    input  logic                      sel_dec,
    input  logic [DEC_ADDR_W-1:0]     decode_addr_dec,
    input  logic [1:0]                trans_dec,
    input  logic [NUM_MI-1:0]         active_dec_vec,
    input  logic [NUM_MI-1:0]         readyout_dec_vec,
    input  logic [2*NUM_MI-1:0]       resp_dec_vec,
    input  logic [RDATA_W*NUM_MI-1:0] rdata_dec_vec,
    input  logic [RUSER_W*NUM_MI-1:0] ruser_dec_vec,
`ifdef AHB_DECODE_REMAP_EN
    input  logic                      remap,
`endif
    output logic [NUM_MI-1:0]         sel_dec_vec,
    output logic                      active_dec,
    output logic                      HREADYOUTS,
    output logic [1:0]                HRESPS,
    output logic [RDATA_W-1:0]        HRDATAS,
    output logic [RUSER_W-1:0]        HRUSERS
);

    localparam logic [NUM_MI:0] DS_PORT = {1'b1, {NUM_MI{1'b0}}};

    logic              remap_act;
    logic [NUM_MI-1:0] region_hit;
    logic [NUM_MI-1:0] first_hit;
    logic [NUM_MI:0]   addr_port;
    logic [NUM_MI:0]   data_port_reg;
    logic              ds_req;
    logic              ds_readyout;
    logic [1:0]        ds_resp;

`ifdef AHB_DECODE_REMAP_EN
    assign remap_act = remap;
`else
    assign remap_act = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NUM_MI; gi++) begin : g_region
            localparam logic [DEC_ADDR_W-1:0] BASE  = REGION_BASE[gi*DEC_ADDR_W +: DEC_ADDR_W];
            localparam logic [DEC_ADDR_W-1:0] LIMIT = REGION_LIMIT[gi*DEC_ADDR_W +: DEC_ADDR_W];
            logic in_region;
            assign in_region = addr_in_range(decode_addr_dec, BASE, LIMIT);
            if (gi == 0) begin : g_port0
                logic in_remap;
                assign in_remap       = addr_in_range(decode_addr_dec, REMAP_BASE, REMAP_LIMIT);
                assign region_hit[gi] = remap_act ? in_remap : in_region;
            end else begin : g_portn
                assign region_hit[gi] = in_region;
            end
        end
    endgenerate

    // Isolate the lowest set bit so the lowest-index port wins on overlapping regions.
    assign first_hit = region_hit & (~region_hit + NUM_MI'(1));

    // An IDLE keeps pointing at the port that owns the current data phase.
    always_comb begin
        if (trans_dec == HTRANS_IDLE && !data_port_reg[NUM_MI]) begin
            addr_port = data_port_reg;
        end else if (|region_hit) begin
            addr_port = {1'b0, first_hit};
        end else begin
            addr_port = DS_PORT;
        end
    end

    assign sel_dec_vec = (sel_dec && !HRESET) ? addr_port[NUM_MI-1:0] : '0;
    assign active_dec  = |(addr_port & {1'b1, active_dec_vec});
    assign ds_req      = addr_port[NUM_MI] & sel_dec & HREADYS &
                         ((trans_dec == HTRANS_NONSEQ) || (trans_dec == HTRANS_SEQ));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            data_port_reg <= DS_PORT;
        end else if (HREADYS) begin
            data_port_reg <= addr_port;
        end
    end

    ahb_matrix_default_slave_ah u_default_slave (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .xfer_req    (ds_req),
        .ds_readyout (ds_readyout),
        .ds_resp     (ds_resp)
    );

    // AND-OR mux over the one-hot data-phase port; the default slave supplies no data.
    always_comb begin
        HREADYOUTS = data_port_reg[NUM_MI] & ds_readyout;
        HRESPS     = data_port_reg[NUM_MI] ? ds_resp : HRESP_OKAY;
        HRDATAS    = '0;
        HRUSERS    = '0;
        for (int i = 0; i < NUM_MI; i++) begin
            if (data_port_reg[i]) begin
                HREADYOUTS = HREADYOUTS | readyout_dec_vec[i];
                HRESPS     = HRESPS | resp_dec_vec[2*i +: 2];
                HRDATAS    = HRDATAS | rdata_dec_vec[RDATA_W*i +: RDATA_W];
                HRUSERS    = HRUSERS | ruser_dec_vec[RUSER_W*i +: RUSER_W];
            end
        end
    end

endmodule
